// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - decode-side request and hazard-control response bundle
interface hazard_unit_if #(
   parameter int REG_AW = 5
);
   logic              d_valid;
   logic [REG_AW-1:0] d_rs_addr;
   logic [REG_AW-1:0] d_rt_addr;
   logic              d_uses_rs;
   logic              d_uses_rt;
   logic              d_wr_en;
   logic [REG_AW-1:0] d_wr_addr;
   logic              d_is_load;
   logic              d_is_muldiv;
   logic              flush;
   logic              stall;
   logic              x_hold;
   logic              fwdX_rs;
   logic              fwdX_rt;
   logic              fwdM_rs;
   logic              fwdM_rt;

   modport master (
      output d_valid, d_rs_addr, d_rt_addr, d_uses_rs, d_uses_rt,
             d_wr_en, d_wr_addr, d_is_load, d_is_muldiv, flush,
      input  stall, x_hold, fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt
   );

   modport slave (
      input  d_valid, d_rs_addr, d_rt_addr, d_uses_rs, d_uses_rt,
             d_wr_en, d_wr_addr, d_is_load, d_is_muldiv, flush,
      output stall, x_hold, fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt
   );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - D/X/M hazard detection: forwarding selects, load-use stall, mul/div hold
module hazard_unit #(
   parameter int REG_AW     = 5,
   parameter int MULDIV_LAT = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   hazard_unit_if.slave hif
);
   typedef struct packed {
      logic              valid;
      logic              wr_en;
      logic [REG_AW-1:0] wr_addr;
      logic              is_load;
   } shadow_t;

   localparam shadow_t    BUBBLE   = '0;
   localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LAT - 1);

   shadow_t    x_sh;
   shadow_t    m_sh;
   logic [3:0] cnt;

   logic busy;
   logic load_use;
   logic accept;
   logic x_rs_raw, x_rt_raw;
   logic x_rs_fwd, x_rt_fwd;
   logic m_rs_fwd, m_rt_fwd;

   // load_ready=0 rejects loads, whose data does not exist until the entry leaves X
   function automatic logic src_hit(input shadow_t           e,
                                    input logic [REG_AW-1:0] src,
                                    input logic              uses,
                                    input logic              load_ready);
      return e.valid && e.wr_en && (e.wr_addr == src) && (e.wr_addr != '0)
             && uses && (load_ready || !e.is_load);
   endfunction

   always_comb begin
      x_rs_raw = src_hit(x_sh, hif.d_rs_addr, hif.d_uses_rs, 1'b1);
      x_rt_raw = src_hit(x_sh, hif.d_rt_addr, hif.d_uses_rt, 1'b1);
      x_rs_fwd = src_hit(x_sh, hif.d_rs_addr, hif.d_uses_rs, 1'b0);
      x_rt_fwd = src_hit(x_sh, hif.d_rt_addr, hif.d_uses_rt, 1'b0);
      m_rs_fwd = src_hit(m_sh, hif.d_rs_addr, hif.d_uses_rs, 1'b1);
      m_rt_fwd = src_hit(m_sh, hif.d_rt_addr, hif.d_uses_rt, 1'b1);

      busy     = (cnt != 4'd0);
      load_use = hif.d_valid && x_sh.is_load && (x_rs_raw || x_rt_raw);
      accept   = hif.d_valid && !hif.flush && !load_use;

      hif.stall   = busy || (load_use && !hif.flush);
      hif.x_hold  = busy;
      hif.fwdX_rs = !busy && x_rs_fwd;
      hif.fwdX_rt = !busy && x_rt_fwd;
      hif.fwdM_rs = !busy && m_rs_fwd && !x_rs_fwd;
      hif.fwdM_rt = !busy && m_rt_fwd && !x_rt_fwd;
   end

   // While busy the mul/div stays parked in X and M drains with bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_sh <= BUBBLE;
         m_sh <= BUBBLE;
         cnt  <= 4'd0;
      end else if (busy) begin
         m_sh <= BUBBLE;
         cnt  <= cnt - 4'd1;
      end else begin
         m_sh <= x_sh;
         if (accept) begin
            x_sh <= '{1'b1, hif.d_wr_en, hif.d_wr_addr, hif.d_is_load};
            cnt  <= hif.d_is_muldiv ? CNT_LOAD : 4'd0;
         end else begin
            x_sh <= BUBBLE;
            cnt  <= 4'd0;
         end
      end
   end
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed scenarios plus randomized run against a pipeline-occupancy model
module tb_hazard_unit;
   localparam int REG_AW = 5;
   localparam int LAT    = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   hazard_unit_if #(.REG_AW(REG_AW)) hif ();

   hazard_unit #(.REG_AW(REG_AW), .MULDIV_LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hif   (hif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {stall, x_hold, fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt}
   logic [5:0] outs;
   assign outs = {hif.stall, hif.x_hold, hif.fwdX_rs, hif.fwdX_rt, hif.fwdM_rs, hif.fwdM_rt};

   typedef struct {
      bit valid;
      bit wr_en;
      int wr_addr;
      bit is_load;
      bit is_muldiv;
   } instr_t;

   instr_t mx;
   instr_t mm;
   int     mx_age;

   function automatic instr_t no_instr();
      instr_t b;
      b.valid = 0; b.wr_en = 0; b.wr_addr = 0; b.is_load = 0; b.is_muldiv = 0;
      return b;
   endfunction

   function automatic bit reads(instr_t w, int src, bit uses);
      return w.valid && w.wr_en && (w.wr_addr == src) && (src != 0) && uses;
   endfunction

   function automatic bit mdl_busy();
      return mx.valid && mx.is_muldiv && (mx_age < LAT - 1);
   endfunction

   function automatic logic [5:0] exp_outs();
      bit b, xrs, xrt, lu, fxrs, fxrt, fmrs, fmrt;
      int rs, rt;
      rs   = int'(hif.d_rs_addr);
      rt   = int'(hif.d_rt_addr);
      b    = mdl_busy();
      xrs  = reads(mx, rs, hif.d_uses_rs);
      xrt  = reads(mx, rt, hif.d_uses_rt);
      lu   = hif.d_valid && mx.is_load && (xrs || xrt);
      fxrs = !b && xrs && !mx.is_load;
      fxrt = !b && xrt && !mx.is_load;
      fmrs = !b && reads(mm, rs, hif.d_uses_rs) && !fxrs;
      fmrt = !b && reads(mm, rt, hif.d_uses_rt) && !fxrt;
      return {b || (lu && !hif.flush), b, fxrs, fxrt, fmrs, fmrt};
   endfunction

   task automatic model_reset();
      mx     = no_instr();
      mm     = no_instr();
      mx_age = 0;
   endtask

   task automatic model_advance();
      bit     lu;
      instr_t d;
      if (!rst_n) begin
         model_reset();
      end else if (mdl_busy()) begin
         mm     = no_instr();
         mx_age = mx_age + 1;
      end else begin
         lu = exp_outs() != 6'b0 && mx.is_load && hif.d_valid &&
              (reads(mx, int'(hif.d_rs_addr), hif.d_uses_rs) || reads(mx, int'(hif.d_rt_addr), hif.d_uses_rt));
         mm = mx;
         if (hif.d_valid && !hif.flush && !lu) begin
            d.valid = 1; d.wr_en = hif.d_wr_en; d.wr_addr = int'(hif.d_wr_addr);
            d.is_load = hif.d_is_load; d.is_muldiv = hif.d_is_muldiv;
            mx = d;
         end else begin
            mx = no_instr();
         end
         mx_age = 0;
      end
   endtask

   task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit wen, input int wa, input bit ld, input bit md, input bit fl);
      hif.d_valid     = v;
      hif.d_rs_addr   = REG_AW'(rs);
      hif.d_rt_addr   = REG_AW'(rt);
      hif.d_uses_rs   = urs;
      hif.d_uses_rt   = urt;
      hif.d_wr_en     = wen;
      hif.d_wr_addr   = REG_AW'(wa);
      hif.d_is_load   = ld;
      hif.d_is_muldiv = md;
      hif.flush       = fl;
      #1;
   endtask

   task automatic step();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      drive(1, 3, 3, 1, 1, 1, 3, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (outs !== 6'b000000) begin
         n_errors++;
         $display("FAIL reset_outs: got %b want 000000", outs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (outs !== 6'b000000) begin
         n_errors++;
         $display("FAIL reset_release_outs: got %b want 000000", outs);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_alu_forward();
      idle(2);
      drive(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
      step();
      drive(1, 3, 0, 1, 0, 1, 7, 0, 0, 0);
      n_checks++;
      if (outs !== 6'b001000) begin
         n_errors++;
         $display("FAIL alu_fwdx_rs: got %b want 001000", outs);
      end
      idle(2);
      drive(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
      step();
      drive(1, 1, 0, 1, 0, 1, 7, 0, 0, 0);
      step();
      drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (outs !== 6'b000010) begin
         n_errors++;
         $display("FAIL alu_gap_fwdm_rs: got %b want 000010", outs);
      end
      step();
   endtask

   task automatic test_r0_priority();
      idle(2);
      drive(1, 1, 1, 1, 1, 1, 0, 0, 0, 0);
      step();
      drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      n_checks++;
      if (outs !== 6'b000000) begin
         n_errors++;
         $display("FAIL r0_no_fwd: got %b want 000000", outs);
      end
      idle(2);
      drive(1, 1, 1, 1, 1, 1, 5, 0, 0, 0);
      step();
      drive(1, 2, 2, 1, 1, 1, 5, 0, 0, 0);
      step();
      drive(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
      n_checks++;
      if (outs !== 6'b000100) begin
         n_errors++;
         $display("FAIL x_priority_rt: got %b want 000100", outs);
      end
      step();
   endtask

   task automatic test_load_use();
      idle(2);
      drive(1, 1, 0, 1, 0, 1, 4, 1, 0, 0);
      step();
      drive(1, 4, 0, 1, 0, 1, 9, 0, 0, 0);
      n_checks++;
      if (outs !== 6'b100000) begin
         n_errors++;
         $display("FAIL load_use_stall: got %b want 100000", outs);
      end
      step();
      n_checks++;
      if (outs !== 6'b000010) begin
         n_errors++;
         $display("FAIL load_use_after: got %b want 000010", outs);
      end
      idle(2);
      drive(1, 1, 0, 1, 0, 1, 4, 1, 0, 0);
      step();
      drive(1, 4, 0, 1, 0, 1, 9, 0, 0, 1);
      n_checks++;
      if (outs !== 6'b000000) begin
         n_errors++;
         $display("FAIL load_use_flush: got %b want 000000", outs);
      end
      step();
      drive(1, 9, 4, 1, 1, 0, 0, 0, 0, 0);
      n_checks++;
      if (outs !== 6'b000001) begin
         n_errors++;
         $display("FAIL flush_bubble_in_x: got %b want 000001", outs);
      end
      step();
   endtask

   task automatic test_muldiv();
      idle(2);
      drive(1, 1, 0, 1, 0, 1, 8, 0, 0, 0);
      step();
      drive(1, 1, 0, 1, 0, 1, 6, 0, 1, 0);
      step();
      for (int i = 0; i < LAT - 1; i++) begin
         drive(1, 6, 8, 1, 1, 1, 10, 0, 0, 0);
         n_checks++;
         if (outs !== 6'b110000) begin
            n_errors++;
            $display("FAIL muldiv_busy_%0d: got %b want 110000", i, outs);
         end
         step();
      end
      n_checks++;
      if (outs !== 6'b001000) begin
         n_errors++;
         $display("FAIL muldiv_release: got %b want 001000", outs);
      end
      step();
      drive(1, 6, 0, 1, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (outs !== 6'b000010) begin
         n_errors++;
         $display("FAIL muldiv_in_m: got %b want 000010", outs);
      end
      step();
   endtask

   task automatic test_reset_mid_muldiv();
      idle(2);
      drive(1, 1, 0, 1, 0, 1, 6, 0, 1, 0);
      step();
      drive(1, 6, 6, 1, 1, 0, 0, 0, 0, 0);
      step();
      n_checks++;
      if (outs !== 6'b110000) begin
         n_errors++;
         $display("FAIL rst_mul_precond: got %b want 110000", outs);
      end
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (outs !== 6'b000000) begin
         n_errors++;
         $display("FAIL rst_mul_async: got %b want 000000", outs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (outs !== 6'b000000) begin
         n_errors++;
         $display("FAIL rst_mul_first_cycle: got %b want 000000", outs);
      end
      step();
      n_checks++;
      if (outs !== 6'b000000) begin
         n_errors++;
         $display("FAIL rst_mul_no_writer: got %b want 000000", outs);
      end
      drive(1, 1, 0, 1, 0, 1, 11, 0, 0, 0);
      step();
      drive(1, 11, 0, 1, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (outs !== 6'b001000) begin
         n_errors++;
         $display("FAIL rst_mul_new_writer: got %b want 001000", outs);
      end
      step();
   endtask

   task automatic test_ignored_operands();
      idle(2);
      drive(1, 1, 0, 1, 0, 1, 4, 1, 0, 0);
      step();
      drive(1, 1, 4, 1, 0, 1, 13, 0, 0, 0);
      n_checks++;
      if (outs !== 6'b000000) begin
         n_errors++;
         $display("FAIL unused_rt_no_stall: got %b want 000000", outs);
      end
      step();
      drive(0, 0, 0, 0, 0, 1, 12, 0, 0, 0);
      step();
      drive(1, 12, 13, 1, 1, 0, 0, 0, 0, 0);
      n_checks++;
      if (outs !== 6'b000001) begin
         n_errors++;
         $display("FAIL invalid_is_bubble: got %b want 000001", outs);
      end
      step();
   endtask

   task automatic test_random();
      logic [5:0] want;
      idle(3);
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 9) < 8,
               $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 4) != 0, $urandom_range(0, 7),
               $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) == 0);
         want = exp_outs();
         n_checks++;
         if (outs !== want) begin
            n_errors++;
            $display("FAIL random_%0d: got %b want %b", i, outs, want);
         end
         step();
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_alu_forward();
      test_r0_priority();
      test_load_use();
      test_muldiv();
      test_reset_mid_muldiv();
      test_ignored_operands();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
